scan_mux: RTL and testbench

//  Parametrised N-channel, W-bit time-multiplexing selector for the 7-seg display path.

---
 rtl/scan_mux_pkg.sv | 23 ++
 rtl/scan_mux_tick_div.sv | 34 +++
 rtl/scan_mux.sv | 94 +++++++++
 tb/tb_scan_mux.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// Shared definitions for the 7-seg scan multiplexer.
//   MODE_AUTO / MODE_MANUAL : encodings of the scan_mux 'mode' input
//   SCAN_DIV_DEFAULT        : prescale for a 100 MHz clock and 1 kHz digit rate
//   onehot()                : N-bit one-hot vector with bit 'idx' set
package scan_mux_pkg;

  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

  // 100_000_000 Hz / 1_000 Hz per digit
  localparam int SCAN_DIV_DEFAULT = 100000;

  // One-hot vector up to 32 bits wide; callers truncate to their channel count.
  function automatic logic [31:0] onehot(input int unsigned idx);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (idx == i) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/scan_mux_tick_div.sv
// Prescaler for the scan multiplexer.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high clear of the count
//   en   : count enable; the count holds while low
//   wrap : combinational, high during the cycle in which the count is DIV-1
//          and en is high, i.e. the edge that ends this cycle wraps to 0
module tick_div #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic wrap
);

  // Keep at least one bit so DIV=1 still elaborates.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  assign wrap    = en & at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// N-channel, W-bit time-multiplexing selector for the 7-seg display path.
// Auto-scans channels at a prescaled rate or follows a manual select, and
// drives a registered data bus plus a one-hot channel enable.
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active-high
//   mode       : 0 = auto scan, 1 = manual
//   man_sel    : channel index used in manual mode (ignored if >= N_CH)
//   freeze     : 1 = hold prescaler and channel index
//   blank_mask : bit i = 1 blanks channel i
//   data_in    : channel i = data_in[i*W +: W]
//   data_out   : registered selected data (0 when blanked)
//   ch_sel     : current channel index (registered)
//   ch_en      : registered one-hot enable (0 when blanked or after reset)
//   tick       : one-cycle pulse following each auto advance
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int N_CH     = 8,
  parameter  int W        = 4,
  parameter  int SCAN_DIV = SCAN_DIV_DEFAULT,
  localparam int SEL_W    = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SEL_W-1:0]  man_sel,
  input  logic              freeze,
  input  logic [N_CH-1:0]   blank_mask,
  input  logic [N_CH*W-1:0] data_in,
  output logic [W-1:0]      data_out,
  output logic [SEL_W-1:0]  ch_sel,
  output logic [N_CH-1:0]   ch_en,
  output logic              tick
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic div_en;
  logic div_rst;
  logic wrap;
  logic man_ok;
  logic blanked;

  // The prescaler only runs while auto-scanning. Holding it in clear while in
  // manual mode guarantees a fresh full slot when auto scanning resumes.
  assign div_en  = (mode == MODE_AUTO) & ~freeze;
  assign div_rst = rst | (mode == MODE_MANUAL);

  tick_div #(.DIV(SCAN_DIV)) u_div (
    .clk  (clk),
    .rst  (div_rst),
    .en   (div_en),
    .wrap (wrap)
  );

  assign man_ok  = (32'(man_sel) < N_CH);
  assign blanked = blank_mask[ch_sel];

  // Channel index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_sel <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!freeze) begin
        if (mode == MODE_AUTO) begin
          if (wrap) begin
            ch_sel <= (ch_sel == LAST_CH) ? '0 : ch_sel + 1'b1;
            tick   <= 1'b1;
          end
        end else if (man_ok) begin
          ch_sel <= man_sel;
        end
      end
    end
  end

  // Output stage: follows ch_sel/data_in/blank_mask one cycle later, and keeps
  // tracking data_in even while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      ch_en    <= '0;
    end else if (blanked) begin
      data_out <= '0;
      ch_en    <= '0;
    end else begin
      data_out <= data_in[32'(ch_sel)*W +: W];
      ch_en    <= N_CH'(onehot(32'(ch_sel)));
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main DUT: N_CH=4, W=4, SCAN_DIV=3
  logic        mode;
  logic [1:0]  man_sel;
  logic        freeze;
  logic [3:0]  blank_mask;
  logic [15:0] data_in;
  logic [3:0]  data_out;
  logic [1:0]  ch_sel;
  logic [3:0]  ch_en;
  logic        tick;

  scan_mux #(.N_CH(4), .W(4), .SCAN_DIV(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .man_sel    (man_sel),
    .freeze     (freeze),
    .blank_mask (blank_mask),
    .data_in    (data_in),
    .data_out   (data_out),
    .ch_sel     (ch_sel),
    .ch_en      (ch_en),
    .tick       (tick)
  );

  // Second DUT: N_CH=3, so man_sel=3 is out of range
  logic        mode3;
  logic [1:0]  man_sel3;
  logic        freeze3;
  logic [2:0]  blank_mask3;
  logic [11:0] data_in3;
  logic [3:0]  data_out3;
  logic [1:0]  ch_sel3;
  logic [2:0]  ch_en3;
  logic        tick3;

  scan_mux #(.N_CH(3), .W(4), .SCAN_DIV(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode3),
    .man_sel    (man_sel3),
    .freeze     (freeze3),
    .blank_mask (blank_mask3),
    .data_in    (data_in3),
    .data_out   (data_out3),
    .ch_sel     (ch_sel3),
    .ch_en      (ch_en3),
    .tick       (tick3)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic        m;
    logic [1:0]  ms;
    logic        f;
    logic [3:0]  b;
    logic [15:0] d;
    logic [1:0]  e_sel;
    logic        e_tick;
    logic [3:0]  e_dout;
    logic [3:0]  e_en;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic m, input logic [1:0] ms, input logic f,
                     input logic [3:0] b, input logic [15:0] d, input logic [1:0] es,
                     input logic et, input logic [3:0] ed, input logic [3:0] een);
    vec_t v;
    v.r = r; v.m = m; v.ms = ms; v.f = f; v.b = b; v.d = d;
    v.e_sel = es; v.e_tick = et; v.e_dout = ed; v.e_en = een;
    vecs.push_back(v);
  endtask

  localparam logic [15:0] D0 = 16'hDCBA;
  localparam logic [15:0] D1 = 16'hDC5A;

  int n;
  bit seen;

  initial begin
    rst = 1'b1; mode = 1'b0; man_sel = 2'd0; freeze = 1'b0;
    blank_mask = 4'b0; data_in = D0;
    mode3 = 1'b1; man_sel3 = 2'd0; freeze3 = 1'b0; blank_mask3 = 3'b0;
    data_in3 = 12'h321;

    // -- reset (2 cycles) --
    add(1,0,0,0,4'h0,D0, 0,0,4'h0,4'b0000);
    add(1,0,0,0,4'h0,D0, 0,0,4'h0,4'b0000);
    // -- auto scan: advance every 3rd edge, data one cycle behind ch_sel --
    add(0,0,0,0,4'h0,D0, 0,0,4'hA,4'b0001);
    add(0,0,0,0,4'h0,D0, 0,0,4'hA,4'b0001);
    add(0,0,0,0,4'h0,D0, 1,1,4'hA,4'b0001);
    add(0,0,0,0,4'h0,D0, 1,0,4'hB,4'b0010);
    add(0,0,0,0,4'h0,D0, 1,0,4'hB,4'b0010);
    add(0,0,0,0,4'h0,D0, 2,1,4'hB,4'b0010);
    add(0,0,0,0,4'h0,D0, 2,0,4'hC,4'b0100);
    add(0,0,0,0,4'h0,D0, 2,0,4'hC,4'b0100);
    add(0,0,0,0,4'h0,D0, 3,1,4'hC,4'b0100);
    add(0,0,0,0,4'h0,D0, 3,0,4'hD,4'b1000);
    add(0,0,0,0,4'h0,D0, 3,0,4'hD,4'b1000);
    add(0,0,0,0,4'h0,D0, 0,1,4'hD,4'b1000);
    add(0,0,0,0,4'h0,D0, 0,0,4'hA,4'b0001);
    // -- blank channel 2 only --
    add(0,0,0,0,4'h4,D0, 0,0,4'hA,4'b0001);
    add(0,0,0,0,4'h4,D0, 1,1,4'hA,4'b0001);
    add(0,0,0,0,4'h4,D0, 1,0,4'hB,4'b0010);
    add(0,0,0,0,4'h4,D0, 1,0,4'hB,4'b0010);
    add(0,0,0,0,4'h4,D0, 2,1,4'hB,4'b0010);
    add(0,0,0,0,4'h4,D0, 2,0,4'h0,4'b0000);
    add(0,0,0,0,4'h4,D0, 2,0,4'h0,4'b0000);
    add(0,0,0,0,4'h4,D0, 3,1,4'h0,4'b0000);
    add(0,0,0,0,4'h4,D0, 3,0,4'hD,4'b1000);
    // -- run to ch_sel=1 --
    add(0,0,0,0,4'h0,D0, 3,0,4'hD,4'b1000);
    add(0,0,0,0,4'h0,D0, 0,1,4'hD,4'b1000);
    add(0,0,0,0,4'h0,D0, 0,0,4'hA,4'b0001);
    add(0,0,0,0,4'h0,D0, 0,0,4'hA,4'b0001);
    add(0,0,0,0,4'h0,D0, 1,1,4'hA,4'b0001);
    // -- freeze 10 cycles at ch_sel=1; channel 1 data changes to 5 midway --
    for (int i = 0; i < 10; i++) begin
      if (i < 5) add(0,0,0,1,4'h0,D0, 1,0,4'hB,4'b0010);
      else       add(0,0,0,1,4'h0,D1, 1,0,4'h5,4'b0010);
    end
    // -- release: next advance on the third edge --
    add(0,0,0,0,4'h0,D1, 1,0,4'h5,4'b0010);
    add(0,0,0,0,4'h0,D1, 1,0,4'h5,4'b0010);
    add(0,0,0,0,4'h0,D1, 2,1,4'h5,4'b0010);
    add(0,0,0,0,4'h0,D1, 2,0,4'hC,4'b0100);
    // -- manual man_sel=3: ch_sel next edge, data the edge after, no tick --
    add(0,1,3,0,4'h0,D0, 3,0,4'hC,4'b0100);
    add(0,1,3,0,4'h0,D0, 3,0,4'hD,4'b1000);
    add(0,1,3,0,4'h0,D0, 3,0,4'hD,4'b1000);
    // -- back to auto: resumes from 3 with a fresh slot --
    add(0,0,3,0,4'h0,D0, 3,0,4'hD,4'b1000);
    add(0,0,3,0,4'h0,D0, 3,0,4'hD,4'b1000);
    add(0,0,3,0,4'h0,D0, 0,1,4'hD,4'b1000);
    add(0,0,3,0,4'h0,D0, 0,0,4'hA,4'b0001);

    foreach (vecs[k]) begin
      rst = vecs[k].r; mode = vecs[k].m; man_sel = vecs[k].ms;
      freeze = vecs[k].f; blank_mask = vecs[k].b; data_in = vecs[k].d;
      step();
      chk($sformatf("v%0d ch_sel", k),   32'(ch_sel),   32'(vecs[k].e_sel));
      chk($sformatf("v%0d tick", k),     32'(tick),     32'(vecs[k].e_tick));
      chk($sformatf("v%0d data_out", k), 32'(data_out), 32'(vecs[k].e_dout));
      chk($sformatf("v%0d ch_en", k),    32'(ch_en),    32'(vecs[k].e_en));
    end

    // -- reset pulse mid-slot at ch_sel=2 --
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (ch_sel == 2'd2) seen = 1'b1;
    end
    chk("reach ch_sel=2", 32'(seen), 32'd1);
    step();
    chk("midslot tick", 32'(tick), 32'd0);
    rst = 1'b1;
    step();
    chk("rst ch_sel", 32'(ch_sel), 32'd0);
    chk("rst ch_en", 32'(ch_en), 32'd0);
    chk("rst data_out", 32'(data_out), 32'd0);
    rst = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      n++;
      if (tick) seen = 1'b1;
    end
    chk("post-rst tick seen", 32'(seen), 32'd1);
    chk("post-rst tick latency", 32'(n), 32'd3);
    chk("post-rst ch_sel", 32'(ch_sel), 32'd1);

    // -- N_CH=3 build, manual: out-of-range select holds --
    man_sel3 = 2'd2;
    step();
    chk("n3 sel2", 32'(ch_sel3), 32'd2);
    man_sel3 = 2'd3;
    step();
    chk("n3 sel3 hold", 32'(ch_sel3), 32'd2);
    chk("n3 data", 32'(data_out3), 32'h3);
    chk("n3 en", 32'(ch_en3), 32'b100);
    step();
    chk("n3 sel3 hold2", 32'(ch_sel3), 32'd2);
    chk("n3 tick", 32'(tick3), 32'd0);
    man_sel3 = 2'd1;
    step();
    chk("n3 sel1", 32'(ch_sel3), 32'd1);
    step();
    chk("n3 data1", 32'(data_out3), 32'h2);
    chk("n3 en1", 32'(ch_en3), 32'b010);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
